dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the pipeline MEM-stage interface.
//  Serves load/store requests (address = ALU result, write data = forwarded rt)
//  from an internal word RAM after a fixed, parameterised wait time.
//  Drives a stall line back to the pipeline until each access completes.
//  Replaces the zero-latency data memory so multi-cycle memory can be modelled.
// PARAMETERS
//  ADDR_W       8   word-index bits; RAM depth = 2**ADDR_W words of 32 bits
//  WAIT_CYCLES  2   cycles spent in WAIT before the response; 0 is legal
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   MEM stage presents a load/store this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address; word index = req_addr[ADDR_W+1:2]
//  req_wdata  in   32  store data
//  req_ready  out  1   responder can accept a request (combinational, =state==IDLE)
//  rsp_valid  out  1   one-cycle pulse: access complete
//  rsp_rdata  out  32  load data, valid while rsp_valid=1
//  addr_err   out  1   with rsp_valid: request was misaligned
//  stall      out  1   hold the pipeline (combinational)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state<=IDLE, wait counter<=0, rsp_valid=0,
//   rsp_rdata=0, addr_err=0. RAM contents are not cleared. A reset during
//   WAIT aborts the access; an uncommitted store is never written.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req_ready=1. On req_valid, capture we/addr/wdata into internal
//    registers; go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP
//    if WAIT_CYCLES=0.
//   WAIT: req_ready=0; port inputs are ignored. Decrement the counter each
//    cycle; when counter==0, go to RESP.
//   RESP: rsp_valid=1 for exactly this cycle. A store commits to the RAM at
//    the clock edge that ends RESP. A load presents RAM[idx] on rsp_rdata.
//    Next state is always IDLE; no request is accepted in RESP.
//  Latency: acceptance edge to rsp_valid is WAIT_CYCLES+1 cycles. A
//   back-to-back request can be accepted no earlier than 1 cycle after RESP.
//  stall = (state==IDLE & req_valid) | (state==WAIT); stall is 0 in RESP, so
//   the pipeline advances on the same edge that ends RESP and samples
//   rsp_rdata on that edge.
//  Misaligned (captured addr[1:0]!=0): still follows full latency. In RESP,
//   addr_err=1, rsp_rdata=0, and no RAM write occurs.
//  Out-of-range addresses wrap modulo the depth. Upper address bits above
//   ADDR_W+1 are ignored.
//  Load immediately after a store to the same word returns the new data,
//   because the store committed before the load was accepted.
//  rsp_rdata and addr_err are 0 whenever rsp_valid=0.
// TESTING
//  1 WAIT_CYCLES=2: store 0xDEADBEEF @0x10 -> stall high 3 cycles; rsp_valid
//    on cycle 4 after acceptance; then load @0x10 returns 0xDEADBEEF.
//  2 WAIT_CYCLES=0: load @0x10 -> rsp_valid one cycle after acceptance.
//    req_valid held high -> a new request is accepted on every second cycle.
//  3 Store 0x12345678 @0x402 (misaligned) -> addr_err=1, rsp_rdata=0.
//    Subsequent load @0x400 returns the prior contents unchanged.
//  4 ADDR_W=8: store 0xA5A5A5A5 @0x400 -> load @0x000 returns 0xA5A5A5A5 (wrap).
//  5 Store 0x1 @0x20, then before it completes: rst pulsed in WAIT -> state IDLE,
//    stall=0, rsp_valid never pulses; load @0x20 returns the old value.
//  6 Change req_addr/req_wdata during WAIT -> response reflects the captured
//    request only.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline MEM stage (master) and the data-memory
// responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        addr_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, addr_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, addr_err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures one load/store, waits WAIT_CYCLES, then
// responds for one cycle while stalling the pipeline until the access completes.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                mis_q, mis_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                addr_err_q, addr_err_d;

    logic [31:0] mem [Depth];

    // Address bits above the word index wrap away by design.
    logic unused_addr;
    assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mis_d       = mis_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        addr_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    mis_d   = |bus.req_addr[1:0];
                    idx_d   = bus.req_addr[ADDR_W+1:2];
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Response registers load on entry to RESP; no store can land in between.
        if (state_q != StResp && state_d == StResp) begin
            rsp_valid_d = 1'b1;
            if (mis_d) begin
                addr_err_d = 1'b1;
            end else if (!we_d) begin
                rsp_rdata_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Store commits on the edge that ends RESP; misaligned stores are dropped.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StResp && we_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.stall     = ((state_q == StIdle) && bus.req_valid) || (state_q == StWait);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder share
// one stimulus port, checked against a per-instance word-array memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;  // 0: two-wait instance, 1: zero-wait instance
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ref2 [256];
    logic [31:0] ref0 [256];

    dmem_if b2 ();
    dmem_if b0 ();

    assign b2.req_valid = (sel == 1'b0) ? req_valid : 1'b0;
    assign b0.req_valid = (sel == 1'b1) ? req_valid : 1'b0;
    assign b2.req_we    = req_we;
    assign b0.req_we    = req_we;
    assign b2.req_addr  = req_addr;
    assign b0.req_addr  = req_addr;
    assign b2.req_wdata = req_wdata;
    assign b0.req_wdata = req_wdata;

    logic        m_ready, m_rsp_valid, m_err, m_stall;
    logic [31:0] m_rdata;
    assign m_ready     = sel ? b0.req_ready : b2.req_ready;
    assign m_rsp_valid = sel ? b0.rsp_valid : b2.rsp_valid;
    assign m_err       = sel ? b0.addr_err  : b2.addr_err;
    assign m_stall     = sel ? b0.stall     : b2.stall;
    assign m_rdata     = sel ? b0.rsp_rdata : b2.rsp_rdata;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge with the selected instance idle; returns at a negedge, idle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        int  w;
        int  lat;
        bit  seen;
        w = sel ? 0 : 2;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rdata     = '0;
        err       = 1'b0;
        #1;
        tests_run++;
        if (m_ready !== 1'b1 || m_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_cycle: ready=%b stall=%b, required ready=1 stall=1",
                     m_ready, m_stall);
        end
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(negedge clk);
            lat++;
            if (m_rsp_valid === 1'b1) begin
                seen = 1;
            end else begin
                tests_run++;
                if (m_stall !== 1'b1 || m_rdata !== 32'h0 || m_err !== 1'b0 || m_ready !== 1'b0)
                begin
                    tests_failed++;
                    $display("FAIL wait_cycle: stall=%b ready=%b rdata=%h err=%b, required 1 0 0 0",
                             m_stall, m_ready, m_rdata, m_err);
                end
            end
        end
        tests_run++;
        if (!seen || lat != w + 1 || m_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency: seen=%0d lat=%0d stall=%b, required lat=%0d stall=0",
                     seen, lat, m_stall, w + 1);
        end
        rdata = m_rdata;
        err   = m_err;
        @(negedge clk);
        tests_run++;
        if (m_rsp_valid !== 1'b0 || m_rdata !== 32'h0 || m_err !== 1'b0 || m_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pulse_end: valid=%b rdata=%h err=%b ready=%b, required 0 0 0 1",
                     m_rsp_valid, m_rdata, m_err, m_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            tests_run++;
            if (m_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_rdata !== 32'h0 ||
                m_err !== 1'b0 || m_stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b stall=%b, required 1 0 0 0 0",
                         m_ready, m_rsp_valid, m_rdata, m_err, m_stall);
            end
        end
        rst = 1'b0;
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [31:0] d, r;
        logic        e;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < 256; i++) begin
                d = $urandom;
                access(1'b1, {$urandom_range(0, 4194303), 8'(i), 2'b00}, d, r, e);
                if (s == 0) ref2[i] = d; else ref0[i] = d;
                tests_run++;
                if (e !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fill_err: word %0d err=%b, required 0", i, e);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] r;
        logic        e;
        sel = 1'b0;
        access(1'b1, 32'h10, 32'hDEADBEEF, r, e);
        ref2[4] = 32'hDEADBEEF;
        access(1'b0, 32'h10, 32'h0, r, e);
        tests_run++;
        if (r !== 32'hDEADBEEF || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_then_load: rdata=%h err=%b, required deadbeef 0", r, e);
        end
        access(1'b1, 32'h402, 32'h12345678, r, e);
        tests_run++;
        if (r !== 32'h0 || e !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_store: rdata=%h err=%b, required 0 1", r, e);
        end
        access(1'b0, 32'h400, 32'h0, r, e);
        tests_run++;
        if (r !== ref2[0] || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_no_write: rdata=%h err=%b, required %h 0", r, e, ref2[0]);
        end
        access(1'b1, 32'h400, 32'hA5A5A5A5, r, e);
        ref2[0] = 32'hA5A5A5A5;
        access(1'b0, 32'h000, 32'h0, r, e);
        tests_run++;
        if (r !== 32'hA5A5A5A5 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_load: rdata=%h err=%b, required a5a5a5a5 0", r, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, r, exp_r;
        logic        we, e, exp_e;
        int          idx;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int n = 0; n < 150; n++) begin
                we = 1'($urandom);
                a  = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                d   = $urandom;
                idx = int'(a[9:2]);
                access(we, a, d, r, e);
                exp_e = (a[1:0] != 2'b00);
                exp_r = 32'h0;
                if (!exp_e && !we) exp_r = (s == 0) ? ref2[idx] : ref0[idx];
                if (!exp_e && we) begin
                    if (s == 0) ref2[idx] = d; else ref0[idx] = d;
                end
                tests_run++;
                if (e !== exp_e || (!we && r !== exp_r) || (exp_e && r !== 32'h0)) begin
                    tests_failed++;
                    $display("FAIL random_access: sel=%0d we=%b addr=%h rdata=%h err=%b, required %h %b",
                             s, we, a, r, e, exp_r, exp_e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        sel       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        for (int k = 0; k < 10; k++) begin
            #1;
            tests_run++;
            if ((k % 2 == 0 && (m_ready !== 1'b1 || m_rsp_valid !== 1'b0)) ||
                (k % 2 == 1 && (m_ready !== 1'b0 || m_rsp_valid !== 1'b1 || m_rdata !== ref0[4])))
            begin
                tests_failed++;
                $display("FAIL back_to_back: cycle %0d ready=%b valid=%b rdata=%h, required ready=%0d data %h",
                         k, m_ready, m_rsp_valid, m_rdata, (k % 2 == 0), ref0[4]);
            end
            if (k != 9) @(negedge clk);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] r;
        logic        e;
        sel       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_ready !== 1'b1 || m_stall !== 1'b0 || m_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_wait: ready=%b stall=%b valid=%b, required 1 0 0",
                     m_ready, m_stall, m_rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (m_rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL aborted_pulse: cycle %0d valid=%b, required 0", k, m_rsp_valid);
            end
        end
        access(1'b0, 32'h20, 32'h0, r, e);
        tests_run++;
        if (r !== ref2[8] || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL aborted_store: rdata=%h err=%b, required %h 0", r, e, ref2[8]);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
